// File: rtl/codec_pkg.sv
// Shared constants and helpers for the WM8731 I2S receive/transmit paths.
package codec_pkg;

    localparam int DEF_DATA_W = 24;
    localparam int FRAME_BITS = 64;
    localparam int HALF_BITS  = 32;
    localparam int BITCNT_W   = 6;

    typedef enum logic {
        HALF_LEFT  = 1'b0,
        HALF_RIGHT = 1'b1
    } half_e;

    // True when a slot within a half-frame (0 = MSB) carries sample data.
    function automatic logic in_window(input logic [4:0] slot, input int width);
        return (int'(slot) < width);
    endfunction

endpackage

// File: rtl/i2s_clkgen.sv
// BCLK/LRC generator: divides clk down to the bit clock and tracks the 64-bit frame position.
module i2s_clkgen
    import codec_pkg::*;
#(
    parameter int BCLK_HALF = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                srst,
    output logic                bclk,
    output logic                lrc,
    output logic [BITCNT_W-1:0] bitcnt,
    output logic                rise_stb,
    output logic                fall_stb
);

    localparam int DIV_W = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_HALF - 1);

    logic [DIV_W-1:0]    div_r;
    logic                bclk_r;
    logic [BITCNT_W-1:0] bitcnt_r;
    logic                tc_s;

    assign tc_s     = (div_r == DIV_LAST);
    assign rise_stb = tc_s & ~bclk_r & ~srst;
    assign fall_stb = tc_s &  bclk_r & ~srst;
    assign bclk     = bclk_r;
    assign bitcnt   = bitcnt_r;
    assign lrc      = bitcnt_r[BITCNT_W-1];

    // Divider, bit clock and frame bit counter; the frame position advances on BCLK falls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_r    <= {DIV_W{1'b0}};
            bclk_r   <= 1'b0;
            bitcnt_r <= {BITCNT_W{1'b0}};
        end else if (srst) begin
            div_r    <= {DIV_W{1'b0}};
            bclk_r   <= 1'b0;
            bitcnt_r <= {BITCNT_W{1'b0}};
        end else if (tc_s) begin
            div_r  <= {DIV_W{1'b0}};
            bclk_r <= ~bclk_r;
            if (bclk_r) begin
                bitcnt_r <= bitcnt_r + BITCNT_W'(1);
            end else begin
                bitcnt_r <= bitcnt_r;
            end
        end else begin
            div_r <= div_r + DIV_W'(1);
        end
    end

endmodule

// File: rtl/adc_i2s_rx.sv
// I2S receiver for the WM8731 ADC path: generates BCLK/ADCLRC, deserialises
// left/right samples and hands each pair to a valid/ready consumer.
module adc_i2s_rx
    import codec_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int BCLK_HALF = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    output logic              adc_bclk,
    output logic              adc_lrc,
    input  logic              adc_dat,
    output logic [DATA_W-1:0] adc_left,
    output logic [DATA_W-1:0] adc_right,
    output logic              adc_valid,
    input  logic              adc_ready,
    output logic              adc_ovr,
    input  logic              ovr_clr
);

    logic                srst_s;
    logic [BITCNT_W-1:0] bitcnt_s;
    logic [BITCNT_W-1:0] pos_s;
    logic                rise_stb_s;
    logic                fall_stb_s;
    logic                dat_s1_r;
    logic                dat_s2_r;
    logic                rise_d1_r;
    logic                rise_d2_r;
    logic                frame_ok_r;
    logic                in_win_s;
    logic                left_win_s;
    logic                right_win_s;
    logic                done_s;
    logic [DATA_W-1:0]   left_sh_r;
    logic [DATA_W-1:0]   right_sh_r;
    logic [DATA_W-1:0]   left_r;
    logic [DATA_W-1:0]   right_r;
    logic                valid_r;
    logic                ovr_r;

    assign srst_s = ~en;

    i2s_clkgen #(
        .BCLK_HALF (BCLK_HALF)
    ) u_clkgen (
        .clk      (clk),
        .rst_n    (rst_n),
        .srst     (srst_s),
        .bclk     (adc_bclk),
        .lrc      (adc_lrc),
        .bitcnt   (bitcnt_s),
        .rise_stb (rise_stb_s),
        .fall_stb (fall_stb_s)
    );

    // Slot 0 of each half is the bit after the LRC edge; for 32-bit samples the
    // last right bit lands at bitcnt 0, so the slot math wraps modulo 64.
    assign pos_s       = bitcnt_s - BITCNT_W'(1);
    assign in_win_s    = in_window(pos_s[4:0], DATA_W);
    assign left_win_s  = (pos_s[5] == HALF_LEFT)  && in_win_s;
    assign right_win_s = (pos_s[5] == HALF_RIGHT) && in_win_s;
    assign done_s      = rise_d2_r && right_win_s && frame_ok_r
                         && (pos_s[4:0] == 5'(DATA_W - 1));

    // Two-flop synchroniser for the codec data line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dat_s1_r <= 1'b0;
            dat_s2_r <= 1'b0;
        end else begin
            dat_s1_r <= adc_dat;
            dat_s2_r <= dat_s1_r;
        end
    end

    // Delay the BCLK-rise strobe to line up with the synchroniser latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rise_d1_r <= 1'b0;
            rise_d2_r <= 1'b0;
        end else if (srst_s) begin
            rise_d1_r <= 1'b0;
            rise_d2_r <= 1'b0;
        end else begin
            rise_d1_r <= rise_stb_s;
            rise_d2_r <= rise_d1_r;
        end
    end

    // Frame marker: a pair may only complete if its left MSB was captured in this frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_ok_r <= 1'b0;
        end else if (srst_s) begin
            frame_ok_r <= 1'b0;
        end else if (fall_stb_s && (bitcnt_s == BITCNT_W'(0))) begin
            frame_ok_r <= 1'b0;
        end else if (rise_d2_r && left_win_s && (pos_s[4:0] == 5'd0)) begin
            frame_ok_r <= 1'b1;
        end else begin
            frame_ok_r <= frame_ok_r;
        end
    end

    // MSB-first shift registers for the two half-frames.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            left_sh_r  <= {DATA_W{1'b0}};
            right_sh_r <= {DATA_W{1'b0}};
        end else if (srst_s) begin
            left_sh_r  <= {DATA_W{1'b0}};
            right_sh_r <= {DATA_W{1'b0}};
        end else if (rise_d2_r && left_win_s) begin
            left_sh_r <= {left_sh_r[DATA_W-2:0], dat_s2_r};
        end else if (rise_d2_r && right_win_s) begin
            right_sh_r <= {right_sh_r[DATA_W-2:0], dat_s2_r};
        end else begin
            left_sh_r  <= left_sh_r;
            right_sh_r <= right_sh_r;
        end
    end

    // Output buffer and handshake; en does not touch a pending pair.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            left_r  <= {DATA_W{1'b0}};
            right_r <= {DATA_W{1'b0}};
            valid_r <= 1'b0;
        end else if (done_s && (!valid_r || adc_ready)) begin
            left_r  <= left_sh_r;
            right_r <= {right_sh_r[DATA_W-2:0], dat_s2_r};
            valid_r <= 1'b1;
        end else if (valid_r && adc_ready) begin
            valid_r <= 1'b0;
        end else begin
            valid_r <= valid_r;
        end
    end

    // Sticky overrun: a dropped pair outranks a clear request in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovr_r <= 1'b0;
        end else if (done_s && valid_r && !adc_ready) begin
            ovr_r <= 1'b1;
        end else if (ovr_clr) begin
            ovr_r <= 1'b0;
        end else begin
            ovr_r <= ovr_r;
        end
    end

    assign adc_left  = left_r;
    assign adc_right = right_r;
    assign adc_valid = valid_r;
    assign adc_ovr   = ovr_r;

endmodule
